uart_rx_oversampled: RTL and testbench

Parametrised UART receive front-end with 16x oversampling and a majority-vote bit decision. Frame format and baud rate are set at run time through ports. Received words go into an internal show-ahead FIFO that is drained over a valid/ready stream with per-word error flags. It replaces the fixed-format single-register receiver on the host link path and sits between the board RX pin and the command decoder.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_rx_oversampled.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the oversampled UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_A   = 4'd7;
  localparam logic [3:0] SAMPLE_B   = 4'd8;
  localparam logic [3:0] SAMPLE_C   = 4'd9;
  localparam logic [3:0] OS_LAST    = 4'(OVERSAMPLE - 1);

  function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
    if (bits < 4'd5) return 4'd5;
    if (bits > 4'd8) return 4'd8;
    return bits;
  endfunction

  // Mode 3 is an alias for "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with a separate level counter
module uart_sync_fifo #(
  parameter  int WIDTH   = 10,
  parameter  int DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LEVEL_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push, do_pop;

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gated so an empty FIFO presents zeros rather than stale memory.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_q <= level_q + LEVEL_W'(1);
      else if (do_pop && !do_push) level_q <= level_q - LEVEL_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with majority vote and receive FIFO
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_pin,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [3:0]                    payload_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [7:0]                    m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overrun,
  output logic                          got_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (FIFO_DEPTH < 2 || CLK_FREQ < 1) begin : g_bad_cfg
    $error("uart_rx_oversampled: FIFO_DEPTH must be >= 2 and CLK_FREQ positive");
  end

  logic             rx_meta_q, rx_s_q;
  logic [DIV_W-1:0] tick_cnt_q;
  logic [3:0]       os_cnt_q;
  logic             s7_q, s8_q;
  rx_state_t        state_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       data_q;
  logic             par_err_q, frm_err_q, all_zero_q;
  logic [3:0]       nbits_q;
  parity_mode_t     par_q;
  logic             two_stop_q;
  logic             overrun_q, got_break_q;

  logic tick, at_vote, at_end, vote, final_stop, is_break, frame_done, pop;
  logic fifo_full, fifo_empty;
  logic [9:0] fifo_rd;

  assign tick       = (tick_cnt_q == '0);
  assign at_vote    = tick && (os_cnt_q == SAMPLE_C);
  assign at_end     = tick && (os_cnt_q == OS_LAST);
  assign vote       = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign final_stop = (stop_idx_q == two_stop_q);
  // Break is decided on the first stop bit so two-stop frames do not wait a further bit.
  assign is_break   = enable && at_vote && (state_q == ST_STOP) && !stop_idx_q
                      && !vote && all_zero_q;
  assign frame_done = enable && at_vote && (state_q == ST_STOP) && final_stop && !is_break;
  assign pop        = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      all_zero_q  <= 1'b0;
      nbits_q     <= 4'd8;
      par_q       <= PAR_NONE;
      two_stop_q  <= 1'b0;
      overrun_q   <= 1'b0;
      got_break_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_pin;
      rx_s_q      <= rx_meta_q;
      overrun_q   <= frame_done && fifo_full && !pop;
      got_break_q <= is_break;

      if (tick) begin
        tick_cnt_q <= baud_div;
        os_cnt_q   <= os_cnt_q + 4'd1;
        if (os_cnt_q == SAMPLE_A) s7_q <= rx_s_q;
        if (os_cnt_q == SAMPLE_B) s8_q <= rx_s_q;
      end else begin
        tick_cnt_q <= tick_cnt_q - DIV_W'(1);
      end

      if (!enable) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_s_q) begin
              state_q    <= ST_START;
              tick_cnt_q <= '0;
              os_cnt_q   <= '0;
              nbits_q    <= clamp_bits(payload_bits);
              par_q      <= decode_parity(parity_mode);
              two_stop_q <= two_stop;
              data_q     <= '0;
              par_err_q  <= 1'b0;
              frm_err_q  <= 1'b0;
              all_zero_q <= 1'b1;
              bit_idx_q  <= '0;
              stop_idx_q <= 1'b0;
            end
          end
          ST_START: begin
            if (at_vote && vote) state_q <= ST_IDLE;
            else if (at_end)     state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (at_vote) begin
              data_q[bit_idx_q] <= vote;
              if (vote) all_zero_q <= 1'b0;
            end
            if (at_end) begin
              if ({1'b0, bit_idx_q} == nbits_q - 4'd1)
                state_q <= (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
              else
                bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          ST_PARITY: begin
            if (at_vote) begin
              par_err_q <= (^data_q) ^ vote ^ (par_q == PAR_ODD);
              if (vote) all_zero_q <= 1'b0;
            end
            if (at_end) state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (at_vote) begin
              if (is_break)        state_q <= ST_BREAK_WAIT;
              else if (final_stop) state_q <= ST_IDLE;
              else if (!vote)      frm_err_q <= 1'b1;
            end
            if (at_end) stop_idx_q <= 1'b1;
          end
          ST_BREAK_WAIT: begin
            if (rx_s_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (frame_done),
    .wr_data ({data_q, par_err_q, frm_err_q | ~vote}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_rd[9:2];
  assign m_parity_err = fifo_rd[1];
  assign m_frame_err  = fifo_rd[0];
  assign overrun      = overrun_q;
  assign got_break    = got_break_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

  localparam int BIT = 64;  // baud_div = 3 -> 16 * 4 clocks per bit

  logic        clk = 1'b0;
  logic        reset, rx_pin, enable, two_stop, m_ready;
  logic [15:0] baud_div;
  logic [3:0]  payload_bits;
  logic [1:0]  parity_mode;
  logic [7:0]  m_data;
  logic        m_parity_err, m_frame_err, m_valid, overrun, got_break;
  logic [3:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int ovr_base, brk_base;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;
  logic ovr_prev = 1'b0;
  logic brk_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_oversampled dut (
    .clk          (clk),
    .reset        (reset),
    .rx_pin       (rx_pin),
    .enable       (enable),
    .baud_div     (baud_div),
    .payload_bits (payload_bits),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .overrun      (overrun),
    .got_break    (got_break),
    .fifo_level   (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and polices the pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {m_data, m_parity_err, m_frame_err});
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", {m_data, m_parity_err, m_frame_err}, exp_w);
        end
      end
      if (overrun)   ovr_cnt++;
      if (got_break) brk_cnt++;
      if (overrun || got_break)
        chk("pulse_single_exclusive",
            {overrun & got_break, overrun & ovr_prev, got_break & brk_prev}, 3'b000);
    end
    ovr_prev = overrun;
    brk_prev = got_break;
  end

  task automatic idle_bits(input int n);
    rx_pin = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  // Called just after a negedge; leaves the line high after the stop bit(s).
  task automatic send_frame(input logic [7:0] d, input int nbits, input int pmode,
                            input bit bad_par, input bit two, input bit stop2_zero);
    logic par;
    par = 1'b0;
    for (int i = 0; i < nbits; i++) par ^= d[i];
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_pin = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (pmode == 1 || pmode == 2) begin
      rx_pin = ((pmode == 2) ? ~par : par) ^ bad_par;
      repeat (BIT) @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (BIT) @(negedge clk);
    if (two) begin
      rx_pin = ~stop2_zero;
      repeat (BIT) @(negedge clk);
    end
    rx_pin = 1'b1;
  endtask

  initial begin
    reset = 1'b1; rx_pin = 1'b1; enable = 1'b1; baud_div = 16'd3;
    payload_bits = 4'd8; parity_mode = 2'd0; two_stop = 1'b0; m_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_flags", {m_parity_err, m_frame_err}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_got_break", got_break, 0);
    chk("rst_fifo_level", fifo_level, 0);
    reset = 1'b0;
    idle_bits(1);

    // 8N1 0xA5: start seen 3 clocks after the edge, stop vote at os 9 of bit 9.
    exp_q.push_back({8'hA5, 2'b00});
    fork
      send_frame(8'hA5, 8, 0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3 + 4 * (16 * 9 + 9)) @(posedge clk);
        #1 chk("a5_valid_before", m_valid, 0);
        @(posedge clk);
        #1 chk("a5_valid_after", m_valid, 1);
        chk("a5_level", fifo_level, 1);
        chk("a5_data", m_data, 8'hA5);
      end
    join
    m_ready = 1'b1;
    idle_bits(1);

    // 7E2 0x35: wrong parity, then correct parity with second stop low.
    payload_bits = 4'd7; parity_mode = 2'd1; two_stop = 1'b1;
    exp_q.push_back({8'h35, 2'b10});
    send_frame(8'h35, 7, 1, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    exp_q.push_back({8'h35, 2'b01});
    send_frame(8'h35, 7, 1, 1'b0, 1'b1, 1'b1);
    idle_bits(2);
    payload_bits = 4'd8; parity_mode = 2'd0; two_stop = 1'b0;

    // Short glitch must be rejected.
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(2);
    chk("glitch_level", fifo_level, 0);

    // Break: 12 bit times low.
    brk_base = brk_cnt;
    rx_pin = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    idle_bits(2);
    chk("break_pulses", brk_cnt - brk_base, 1);
    chk("break_level", fifo_level, 0);
    exp_q.push_back({8'h5A, 2'b00});
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 1'b0);
    idle_bits(2);

    // Overrun: nine frames into an eight-deep FIFO.
    m_ready = 1'b0;
    ovr_base = ovr_cnt;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back({8'(i), 2'b00});
      send_frame(8'(i), 8, 0, 1'b0, 1'b0, 1'b0);
      idle_bits(1);
    end
    chk("ovr_level", fifo_level, 8);
    chk("ovr_pulses", ovr_cnt - ovr_base, 1);
    m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_level", fifo_level, 0);

    // Reset in the middle of the data bits.
    ovr_base = ovr_cnt;
    brk_base = brk_cnt;
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
    repeat (BIT + BIT / 2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_bits(12);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_pulses", (ovr_cnt - ovr_base) + (brk_cnt - brk_base), 0);
    exp_q.push_back({8'h3C, 2'b00});
    send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 1'b0);
    idle_bits(2);

    // Enable dropped mid-frame: the all-ones frame would otherwise complete.
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    enable = 1'b0;
    idle_bits(12);
    enable = 1'b1;
    idle_bits(2);
    chk("enable_drop_level", fifo_level, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
